// File: rtl/line_feed_sequencer.sv
// Line feed sequencer: meters source image lines into a line-buffered core.
// A prefill burst loads the first lines, then each further line (and each
// trailing padding line) is released by one core interrupt. After the last
// padding line the sequencer waits for the core's full output pixel count.
module line_feed_sequencer #(
   parameter int PIX_W         = 8,
   parameter int IMG_W         = 512,
   parameter int IMG_H         = 512,
   parameter int PREFILL_LINES = 4,
   parameter int PAD_LINES     = 2,
   parameter int PAD_VALUE     = 0,
   parameter int OUT_PIXELS    = 512*506
) (
   input  logic             axi_clk,
   input  logic             axi_reset,
   input  logic             i_start,
   input  logic [PIX_W-1:0] s_data,
   input  logic             s_valid,
   output logic             s_ready,
   output logic [PIX_W-1:0] o_data,
   output logic             o_data_valid,
   input  logic             i_intr,
   input  logic             i_core_valid,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_overrun
);

   localparam int PIX_CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int LINE_CW = $clog2(IMG_H + 1);
   localparam int PAD_CW  = (PAD_LINES > 0) ? $clog2(PAD_LINES + 1) : 1;
   localparam int OUT_CW  = $clog2(OUT_PIXELS + 1);

   localparam logic [PIX_CW-1:0]  PIX_LAST  = PIX_CW'(IMG_W - 1);
   localparam logic [LINE_CW-1:0] LINES_ALL = LINE_CW'(IMG_H);
   localparam logic [LINE_CW-1:0] LINES_PRE = LINE_CW'(PREFILL_LINES);
   localparam logic [PAD_CW-1:0]  PADS_ALL  = PAD_CW'(PAD_LINES);
   localparam logic [OUT_CW-1:0]  OUT_ALL   = OUT_CW'(OUT_PIXELS);
   localparam logic [PIX_W-1:0]   PAD_PIX   = PIX_W'(PAD_VALUE);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREFILL,
      S_WAIT_LINE,
      S_LINE,
      S_WAIT_PAD,
      S_PAD,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t state;
   state_t state_next;
   state_t src_done_state;

   logic [PIX_CW-1:0]  pix_count;
   logic [LINE_CW-1:0] lines_sent;
   logic [PAD_CW-1:0]  pad_count;
   logic [OUT_CW-1:0]  out_count;
   logic               intr_q;
   logic               intr_pending;
   logic               overrun;

   logic [PIX_W-1:0]   data_p1;
   logic               vld_p1;

   logic               start_ok;
   logic               transfer;
   logic               line_end;
   logic               intr_edge;
   logic               consume;
   logic [LINE_CW-1:0] lines_inc;
   logic [PAD_CW-1:0]  pad_inc;

   assign start_ok  = ((state == S_IDLE) || (state == S_DONE)) && i_start;
   assign transfer  = s_valid && s_ready;
   assign line_end  = (pix_count == PIX_LAST);
   assign intr_edge = i_intr && !intr_q;
   assign consume   = ((state == S_WAIT_LINE) || (state == S_WAIT_PAD)) && intr_pending;
   assign lines_inc = lines_sent + LINE_CW'(1);
   assign pad_inc   = pad_count + PAD_CW'(1);

   // Where a finished source line leads: another line, padding, or straight to drain
   assign src_done_state = (lines_inc < LINES_ALL) ? S_WAIT_LINE :
                           (PAD_LINES > 0)         ? S_WAIT_PAD  : S_DRAIN;

   // State register
   always_ff @(posedge axi_clk) begin
      if (axi_reset) state <= S_IDLE;
      else           state <= state_next;
   end

   // Next-state decode; interrupts only release waits, never cut a line short
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE, S_DONE: if (i_start) state_next = S_PREFILL;
         S_PREFILL: begin
            if (transfer && line_end &&
                ((lines_inc == LINES_PRE) || (lines_inc == LINES_ALL)))
               state_next = src_done_state;
         end
         S_LINE:      if (transfer && line_end) state_next = src_done_state;
         S_WAIT_LINE: if (intr_pending) state_next = S_LINE;
         S_WAIT_PAD:  if (intr_pending) state_next = S_PAD;
         S_PAD: begin
            if (line_end) state_next = (pad_inc < PADS_ALL) ? S_WAIT_PAD : S_DRAIN;
         end
         S_DRAIN:     if (out_count == OUT_ALL) state_next = S_DONE;
         default:     state_next = S_IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      s_ready = 1'b0;
      o_busy  = 1'b1;
      o_done  = 1'b0;
      case (state)
         S_IDLE:             o_busy  = 1'b0;
         S_DONE: begin
            o_busy = 1'b0;
            o_done = 1'b1;
         end
         S_PREFILL, S_LINE:  s_ready = 1'b1;
         default:            s_ready = 1'b0;
      endcase
   end

   // Pixel, line, pad and output counters plus interrupt bookkeeping
   always_ff @(posedge axi_clk) begin
      if (axi_reset) begin
         pix_count    <= '0;
         lines_sent   <= '0;
         pad_count    <= '0;
         out_count    <= '0;
         intr_q       <= 1'b0;
         intr_pending <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         intr_q <= i_intr;
         if (start_ok) begin
            pix_count    <= '0;
            lines_sent   <= '0;
            pad_count    <= '0;
            out_count    <= '0;
            intr_pending <= 1'b0;
            overrun      <= 1'b0;
         end else begin
            // pixel position advances on accepted source pixels or every pad cycle
            if (transfer || (state == S_PAD))
               pix_count <= line_end ? '0 : pix_count + PIX_CW'(1);
            if (transfer && line_end)
               lines_sent <= lines_inc;
            if ((state == S_PAD) && line_end)
               pad_count <= pad_inc;
            if (o_busy && i_core_valid && (out_count != OUT_ALL))
               out_count <= out_count + OUT_CW'(1);
            // a new edge outranks a same-cycle consume; an unconsumed pending edge is lost
            if (intr_edge) begin
               intr_pending <= 1'b1;
               if (intr_pending && !consume) overrun <= 1'b1;
            end else if (consume) begin
               intr_pending <= 1'b0;
            end
         end
      end
   end

   // Output pixel register: source pixel or pad value, one cycle after it is taken
   always_ff @(posedge axi_clk) begin
      if (axi_reset) begin
         data_p1 <= '0;
         vld_p1  <= 1'b0;
      end else begin
         vld_p1 <= transfer || (state == S_PAD);
         if (transfer)            data_p1 <= s_data;
         else if (state == S_PAD) data_p1 <= PAD_PIX;
      end
   end

   assign o_data       = data_p1;
   assign o_data_valid = vld_p1;
   assign o_overrun    = overrun;

endmodule

// File: tb/tb_line_feed_sequencer.sv
// Randomised bench for line_feed_sequencer. The reference model tracks the
// image as totals (source pixels taken, pad pixels sent, core pixels seen)
// plus "waiting for interrupt" / "draining" flags, and predicts every output.
module tb_line_feed_sequencer;

   localparam int PIX_W         = 8;
   localparam int IMG_W         = 4;
   localparam int IMG_H         = 6;
   localparam int PREFILL_LINES = 4;
   localparam int PAD_LINES     = 2;
   localparam int PAD_VALUE     = 0;
   localparam int OUT_PIXELS    = 16;
   localparam int SRC_PIX       = IMG_W * IMG_H;
   localparam int RUN_BUDGET    = 3000;

   logic             axi_clk = 1'b0;
   logic             axi_reset;
   logic             i_start;
   logic [PIX_W-1:0] s_data;
   logic             s_valid;
   logic             s_ready;
   logic [PIX_W-1:0] o_data;
   logic             o_data_valid;
   logic             i_intr;
   logic             i_core_valid;
   logic             o_busy;
   logic             o_done;
   logic             o_overrun;

   line_feed_sequencer #(
      .PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .PREFILL_LINES(PREFILL_LINES),
      .PAD_LINES(PAD_LINES), .PAD_VALUE(PAD_VALUE), .OUT_PIXELS(OUT_PIXELS)
   ) dut (
      .axi_clk(axi_clk), .axi_reset(axi_reset), .i_start(i_start),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .o_data(o_data), .o_data_valid(o_data_valid),
      .i_intr(i_intr), .i_core_valid(i_core_valid),
      .o_busy(o_busy), .o_done(o_done), .o_overrun(o_overrun)
   );

   always #5 axi_clk = ~axi_clk;

   // reference model state (value after the most recent clock edge)
   bit               m_busy, m_done, m_wait, m_drain, m_pend, m_ovr, m_intr_q, m_ovalid;
   int               m_in, m_pad, m_out;
   logic [PIX_W-1:0] m_odata;

   int n_tests = 0;
   int n_fail  = 0;
   int p_valid, p_intr, p_core, cyc;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
      end
   endtask

   // advance the model across one clock edge using the inputs now being driven
   task automatic model_step();
      bit edge_i, consume, src, padp, xfer, done_now;
      if (axi_reset) begin
         m_busy = 0; m_done = 0; m_wait = 0; m_drain = 0; m_pend = 0; m_ovr = 0;
         m_intr_q = 0; m_ovalid = 0; m_in = 0; m_pad = 0; m_out = 0; m_odata = '0;
         return;
      end
      edge_i   = i_intr && !m_intr_q;
      m_intr_q = i_intr;
      if (!m_busy && i_start) begin
         m_busy = 1; m_done = 0; m_wait = 0; m_drain = 0; m_pend = 0; m_ovr = 0;
         m_in = 0; m_pad = 0; m_out = 0; m_ovalid = 0;
         return;
      end
      consume = m_busy && m_wait && m_pend;
      if (edge_i) begin
         if (m_pend && !consume) m_ovr = 1;
         m_pend = 1;
      end else if (consume) begin
         m_pend = 0;
      end
      m_ovalid = 0;
      if (!m_busy) return;
      src      = !m_wait && !m_drain && (m_in < SRC_PIX);
      padp     = !m_wait && !m_drain && (m_in == SRC_PIX);
      xfer     = src && s_valid;
      done_now = m_drain && (m_out == OUT_PIXELS);
      if (i_core_valid && (m_out < OUT_PIXELS)) m_out++;
      if (consume) m_wait = 0;
      if (xfer) begin
         m_odata  = s_data;
         m_ovalid = 1;
         m_in++;
         if ((m_in % IMG_W == 0) && (m_in >= PREFILL_LINES * IMG_W)) begin
            if ((m_in == SRC_PIX) && (PAD_LINES == 0)) m_drain = 1;
            else                                       m_wait  = 1;
         end
      end
      if (padp) begin
         m_odata  = PIX_W'(PAD_VALUE);
         m_ovalid = 1;
         m_pad++;
         if (m_pad % IMG_W == 0) begin
            if (m_pad == PAD_LINES * IMG_W) m_drain = 1;
            else                            m_wait  = 1;
         end
      end
      if (done_now) begin
         m_busy = 0;
         m_done = 1;
      end
   endtask

   task automatic check_all();
      chk("s_ready",      32'(s_ready),      32'(m_busy && !m_wait && !m_drain && (m_in < SRC_PIX)));
      chk("o_data_valid", 32'(o_data_valid), 32'(m_ovalid));
      chk("o_data",       32'(o_data),       32'(m_odata));
      chk("o_busy",       32'(o_busy),       32'(m_busy));
      chk("o_done",       32'(o_done),       32'(m_done));
      chk("o_overrun",    32'(o_overrun),    32'(m_ovr));
   endtask

   // run 0: ramp data, s_valid held high, one interrupt pulse per wait
   task automatic drive(input int r, input int c);
      axi_reset = (r == 3) && (c == 12);
      i_start   = !m_busy ? 1'b1 : ($urandom_range(15) == 0);
      if (r == 0) begin
         s_valid = 1'b1;
         s_data  = PIX_W'(m_in);
         i_intr  = m_wait && !m_pend && !i_intr;
      end else begin
         s_valid = (int'($urandom_range(99)) < p_valid);
         s_data  = PIX_W'($urandom);
         i_intr  = (int'($urandom_range(99)) < p_intr);
      end
      i_core_valid = (int'($urandom_range(99)) < p_core);
   endtask

   initial begin
      axi_reset = 1'b1; i_start = 1'b0; s_valid = 1'b0; s_data = '0;
      i_intr = 1'b0; i_core_valid = 1'b0;
      model_step();
      repeat (3) begin
         @(negedge axi_clk);
         check_all();
         model_step();
      end
      axi_reset = 1'b0;
      for (int r = 0; r < 6; r++) begin
         case (r)
            0:       begin p_valid = 100; p_intr = 0;  p_core = 30;  end
            1:       begin p_valid = 50;  p_intr = 30; p_core = 20;  end
            2:       begin p_valid = 80;  p_intr = 60; p_core = 100; end
            3:       begin p_valid = 70;  p_intr = 40; p_core = 50;  end
            4:       begin p_valid = 30;  p_intr = 15; p_core = 5;   end
            default: begin p_valid = 90;  p_intr = 50; p_core = 10;  end
         endcase
         cyc = 0;
         do begin
            @(negedge axi_clk);
            check_all();
            drive(r, cyc);
            model_step();
            cyc++;
         end while (!m_done && (cyc < RUN_BUDGET));
         @(negedge axi_clk);
         check_all();
         chk("run_finished", 32'(o_done), 32'(1));
         axi_reset = 1'b0; i_start = 1'b0; s_valid = 1'b0; i_intr = 1'b0; i_core_valid = 1'b0;
         model_step();
      end
      @(negedge axi_clk);
      check_all();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
